// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer:
// FSM state encoding, ALU control codes, opcode and funct values.
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_BRTGT,
        ST_DONE
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: opcode/funct to ALU control and operand select.
// Optional macro ALU_SEQ_BNE_EN adds bne as an inverted-condition branch.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       use_imm_o,
    output logic       is_branch_o,
    output logic       branch_inv_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o   = ALU_AND;
        use_imm_o    = 1'b0;
        is_branch_o  = 1'b0;
        branch_inv_o = 1'b0;
        illegal_o    = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    F_AND:   alu_ctrl_o = ALU_AND;
                    F_OR:    alu_ctrl_o = ALU_OR;
                    F_ADD:   alu_ctrl_o = ALU_ADD;
                    F_SUB:   alu_ctrl_o = ALU_SUB;
                    F_SLT:   alu_ctrl_o = ALU_SLT;
                    F_NOR:   alu_ctrl_o = ALU_NOR;
                    default: illegal_o  = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_ctrl_o = ALU_ADD;
                use_imm_o  = 1'b1;
            end
            OP_BEQ: begin
                alu_ctrl_o  = ALU_SUB;
                is_branch_o = 1'b1;
            end
`ifdef ALU_SEQ_BNE_EN
            OP_BNE: begin
                alu_ctrl_o   = ALU_SUB;
                is_branch_o  = 1'b1;
                branch_inv_o = 1'b1;
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer driving an external ALU with ALU_LATENCY-cycle result timing.
// Optional macro ALU_SEQ_BNE_EN (handled in alu_op_decode) enables bne.
//
// state  | meaning
// IDLE   | waiting for an instruction, InstrReady high
// DECODE | decode captured instruction, launch ALU op or flag illegal
// EXEC   | hold ALU inputs ALU_LATENCY cycles, capture result
// BRTGT  | branch only: compute PC+4+(simm16<<2) on the ALU
// DONE   | ResultValid high until ResultReady
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        InstrValid,
    output logic        InstrReady,
    input  logic [31:0] Instr,
    input  logic [31:0] PC,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic [3:0]  AluControl,
    output logic [31:0] AluIn1,
    output logic [31:0] AluIn2,
    input  logic [31:0] AluOut,
    input  logic        AluZero,
    output logic        ResultValid,
    input  logic        ResultReady,
    output logic [31:0] Result,
    output logic        BranchTaken,
    output logic [31:0] BranchTarget,
    output logic        Illegal
);

    localparam logic [1:0] CNT_LOAD = 2'(ALU_LATENCY - 1);

    state_t      state_q;
    logic [5:0]  opcode_q;
    logic [15:0] imm_q;
    logic [31:0] pc_q, rs_q, rt_q;
    logic [1:0]  cnt_q;
    logic [3:0]  ctrl_q;
    logic [31:0] in1_q, in2_q, result_q, target_q;
    logic        taken_q, illegal_q, valid_q;

    logic [3:0]  dec_ctrl;
    logic        dec_use_imm, dec_branch, dec_inv, dec_illegal;
    logic [31:0] simm;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^Instr[25:16];
    assign simm = sext16(imm_q);

    alu_op_decode u_decode (
        .opcode_i     (opcode_q),
        .funct_i      (imm_q[5:0]),
        .alu_ctrl_o   (dec_ctrl),
        .use_imm_o    (dec_use_imm),
        .is_branch_o  (dec_branch),
        .branch_inv_o (dec_inv),
        .illegal_o    (dec_illegal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            result_q  <= '0;
            target_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (InstrValid) begin
                        opcode_q  <= Instr[31:26];
                        imm_q     <= Instr[15:0];
                        pc_q      <= PC;
                        rs_q      <= RsData;
                        rt_q      <= RtData;
                        result_q  <= '0;
                        target_q  <= '0;
                        taken_q   <= 1'b0;
                        illegal_q <= 1'b0;
                        state_q   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        ctrl_q  <= dec_ctrl;
                        in1_q   <= rs_q;
                        in2_q   <= dec_use_imm ? simm : rt_q;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 2'd0) begin
                        result_q <= AluOut;
                        if (dec_branch) begin
                            taken_q <= AluZero ^ dec_inv;
                            ctrl_q  <= ALU_ADD;
                            in1_q   <= pc_q + 32'd4;
                            in2_q   <= {simm[29:0], 2'b00};
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_BRTGT;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_BRTGT: begin
                    if (cnt_q == 2'd0) begin
                        target_q <= AluOut;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_DONE: begin
                    if (ResultReady) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign InstrReady   = (state_q == ST_IDLE) && !reset;
    assign AluControl   = ctrl_q;
    assign AluIn1       = in1_q;
    assign AluIn2       = in2_q;
    assign ResultValid  = valid_q;
    assign Result       = result_q;
    assign BranchTaken  = taken_q;
    assign BranchTarget = target_q;
    assign Illegal      = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, reset corner
// cases and randomized instructions against an arithmetic reference model.
module tb_alu_op_sequencer;

    localparam int LAT = 1;
`ifdef ALU_SEQ_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrValid, InstrReady;
    logic [31:0] Instr, PC, RsData, RtData;
    logic [3:0]  AluControl;
    logic [31:0] AluIn1, AluIn2, AluOut;
    logic        AluZero;
    logic        ResultValid, ResultReady;
    logic [31:0] Result, BranchTarget;
    logic        BranchTaken, Illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ALU_LATENCY(LAT)) dut (
        .clock(clk), .reset(reset),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instr(Instr), .PC(PC), .RsData(RsData), .RtData(RtData),
        .AluControl(AluControl), .AluIn1(AluIn1), .AluIn2(AluIn2),
        .AluOut(AluOut), .AluZero(AluZero),
        .ResultValid(ResultValid), .ResultReady(ResultReady),
        .Result(Result), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Illegal(Illegal)
    );

    // Environment ALU (combinational; adequate for LAT=1)
    always_comb begin
        case (AluControl)
            4'd0:    AluOut = AluIn1 & AluIn2;
            4'd1:    AluOut = AluIn1 | AluIn2;
            4'd2:    AluOut = AluIn1 + AluIn2;
            4'd6:    AluOut = AluIn1 - AluIn2;
            4'd7:    AluOut = ($signed(AluIn1) < $signed(AluIn2)) ? 32'd1 : 32'd0;
            4'd12:   AluOut = ~(AluIn1 | AluIn2);
            default: AluOut = 32'd0;
        endcase
    end
    assign AluZero = (AluOut == 32'd0);

    typedef struct {
        logic [31:0] result;
        logic [31:0] target;
        logic        illegal;
        logic        taken;
        int          lat;
        logic [3:0]  ctrl;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        int          hold;
        exp_t        e;
    } vec_t;

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic exp_t ref_model(input logic [31:0] instr, pc, rs, rt);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        int          simm;
        op   = instr[31:26];
        fn   = instr[5:0];
        simm = int'($signed(instr[15:0]));
        e    = '{32'd0, 32'd0, 1'b0, 1'b0, 2 + LAT, 4'hF};
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin e.result = rs + rt;   e.ctrl = 4'd2;  end
                6'h22: begin e.result = rs - rt;   e.ctrl = 4'd6;  end
                6'h24: begin e.result = rs & rt;   e.ctrl = 4'd0;  end
                6'h25: begin e.result = rs | rt;   e.ctrl = 4'd1;  end
                6'h27: begin e.result = ~(rs | rt); e.ctrl = 4'd12; end
                6'h2A: begin e.result = (int'(rs) < int'(rt)) ? 32'd1 : 32'd0; e.ctrl = 4'd7; end
                default: e.illegal = 1'b1;
            endcase
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            e.result = rs + 32'(simm);
            e.ctrl   = 4'd2;
        end else if (op == 6'h04 || (op == 6'h05 && BNE_EN)) begin
            e.result = rs - rt;
            e.taken  = (rs == rt) ^ (op == 6'h05);
            e.target = pc + 32'd4 + 32'(simm * 4);
            e.ctrl   = 4'd6;
            e.lat    = 2 + 2 * LAT;
        end else begin
            e.illegal = 1'b1;
        end
        if (e.illegal) begin
            e.lat = 2;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Starts and ends on a negedge with the DUT expected in IDLE.
    task automatic run_one(input string name, input logic [31:0] instr, pc, rs, rt,
                           input int hold, input exp_t e);
        int         lat;
        logic       rdy_bad;
        logic       hold_bad;
        logic [3:0] ctrl2;
        chk({name, ".ready_idle"}, 32'(InstrReady), 32'd1);
        InstrValid = 1'b1;
        Instr  = instr;
        PC     = pc;
        RsData = rs;
        RtData = rt;
        @(negedge clk);
        InstrValid = 1'b0;
        Instr  = $urandom;
        RsData = $urandom;
        RtData = $urandom;
        lat     = 1;
        rdy_bad = 1'b0;
        ctrl2   = 4'hx;
        while (1) begin
            if (lat == 2) ctrl2 = AluControl;
            if (ResultValid || lat >= 40) break;
            if (InstrReady) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 32'(lat), 32'(e.lat));
        chk({name, ".result"}, Result, e.result);
        chk({name, ".illegal"}, 32'(Illegal), 32'(e.illegal));
        chk({name, ".taken"}, 32'(BranchTaken), 32'(e.taken));
        chk({name, ".target"}, BranchTarget, e.target);
        chk({name, ".ready_busy"}, 32'(rdy_bad), 32'd0);
        if (e.ctrl != 4'hF) chk({name, ".alu_ctrl"}, 32'(ctrl2), 32'(e.ctrl));
        ResultReady = 1'b0;
        hold_bad    = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!ResultValid || Result !== e.result || InstrReady) hold_bad = 1'b1;
        end
        if (hold > 0) chk({name, ".backpressure_hold"}, 32'(hold_bad), 32'd0);
        ResultReady = 1'b1;
        @(negedge clk);
        ResultReady = 1'b0;
        chk({name, ".release"}, {30'd0, ResultValid, InstrReady}, 32'd1);
    endtask

    vec_t vecs[14];

    initial begin
        logic [5:0] fl[7];
        logic       rv_seen;

        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21};

        vecs[0]  = '{{6'h3F, 26'd0}, 32'h0, 32'd3, 32'd4, 0, '{32'd0, 32'd0, 1'b1, 1'b0, 2, 4'd0}};
        vecs[1]  = '{rtype(6'h20), 32'h0, 32'd5, 32'd7, 0, '{32'd12, 32'd0, 1'b0, 1'b0, 3, 4'd2}};
        vecs[2]  = '{rtype(6'h20), 32'h0, 32'd100, 32'd23, 5, '{32'd123, 32'd0, 1'b0, 1'b0, 3, 4'd2}};
        vecs[3]  = '{itype(6'h04, 16'h0003), 32'h100, 32'd9, 32'd9, 0, '{32'd0, 32'h110, 1'b0, 1'b1, 4, 4'd6}};
        vecs[4]  = '{itype(6'h04, 16'hFFFF), 32'h100, 32'd9, 32'd9, 0, '{32'd0, 32'h100, 1'b0, 1'b1, 4, 4'd6}};
        vecs[5]  = '{itype(6'h04, 16'h0010), 32'h200, 32'd1, 32'd2, 1, '{32'hFFFFFFFF, 32'h244, 1'b0, 1'b0, 4, 4'd6}};
        vecs[6]  = '{rtype(6'h22), 32'h0, 32'd7, 32'd10, 0, '{32'hFFFFFFFD, 32'd0, 1'b0, 1'b0, 3, 4'd6}};
        vecs[7]  = '{rtype(6'h2A), 32'h0, 32'hFFFFFFFF, 32'd1, 0, '{32'd1, 32'd0, 1'b0, 1'b0, 3, 4'd7}};
        vecs[8]  = '{rtype(6'h27), 32'h0, 32'hF0F00000, 32'h000000FF, 0, '{32'h0F0FFF00, 32'd0, 1'b0, 1'b0, 3, 4'd12}};
        vecs[9]  = '{rtype(6'h24), 32'h0, 32'hFF00FF00, 32'h0FF00FF0, 0, '{32'h0F000F00, 32'd0, 1'b0, 1'b0, 3, 4'd0}};
        vecs[10] = '{rtype(6'h25), 32'h0, 32'hFF000000, 32'h000000FF, 0, '{32'hFF0000FF, 32'd0, 1'b0, 1'b0, 3, 4'd1}};
        vecs[11] = '{itype(6'h23, 16'hFFFC), 32'h0, 32'h1000, 32'd0, 0, '{32'h00000FFC, 32'd0, 1'b0, 1'b0, 3, 4'd2}};
        vecs[12] = '{rtype(6'h21), 32'h0, 32'd1, 32'd1, 0, '{32'd0, 32'd0, 1'b1, 1'b0, 2, 4'hF}};
`ifdef ALU_SEQ_BNE_EN
        vecs[13] = '{itype(6'h05, 16'h0003), 32'h100, 32'd1, 32'd2, 0, '{32'hFFFFFFFF, 32'h110, 1'b0, 1'b1, 4, 4'd6}};
`else
        vecs[13] = '{itype(6'h05, 16'h0003), 32'h100, 32'd1, 32'd2, 0, '{32'd0, 32'd0, 1'b1, 1'b0, 2, 4'hF}};
`endif

        reset = 1'b1; InstrValid = 1'b0; ResultReady = 1'b0;
        Instr = '0; PC = '0; RsData = '0; RtData = '0;
        repeat (3) @(negedge clk);
        chk("reset.instr_ready", 32'(InstrReady), 32'd0);
        chk("reset.alu_ctrl", 32'(AluControl), 32'd0);
        chk("reset.alu_in", AluIn1 | AluIn2, 32'd0);
        chk("reset.result_target", Result | BranchTarget, 32'd0);
        chk("reset.flags", {29'd0, ResultValid, BranchTaken, Illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].rs,
                    vecs[i].rt, vecs[i].hold, vecs[i].e);
        end

        // Reset while in EXEC, with both handshakes asserted alongside it
        InstrValid = 1'b1; Instr = rtype(6'h20); RsData = 32'd5; RtData = 32'd7;
        @(negedge clk);
        InstrValid = 1'b0;
        @(negedge clk);
        reset = 1'b1; InstrValid = 1'b1; ResultReady = 1'b1;
        @(negedge clk);
        chk("rst_exec.valid", 32'(ResultValid), 32'd0);
        chk("rst_exec.ready_in_reset", 32'(InstrReady), 32'd0);
        chk("rst_exec.outputs", Result | BranchTarget | AluIn1 | AluIn2 | 32'(AluControl), 32'd0);
        @(negedge clk);
        reset = 1'b0; InstrValid = 1'b0; ResultReady = 1'b0;
        rv_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ResultValid) rv_seen = 1'b1;
        end
        chk("rst_exec.no_valid_pulse", 32'(rv_seen), 32'd0);
        chk("rst_exec.idle_ready", 32'(InstrReady), 32'd1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins, pc, rs, rt;
            int          sel;
            sel = $urandom_range(0, 9);
            rs  = $urandom;
            rt  = ($urandom_range(0, 2) == 0) ? rs : $urandom;
            pc  = {$urandom, 2'b00};
            if (sel <= 5) ins = rtype(fl[$urandom_range(0, 6)]);
            else if (sel == 6) ins = itype(($urandom_range(0, 1) == 0) ? 6'h08 : 6'h2B, 16'($urandom));
            else if (sel == 7) ins = itype(6'h04, 16'($urandom));
            else if (sel == 8) ins = itype(6'h05, 16'($urandom));
            else ins = itype(($urandom_range(0, 1) == 0) ? 6'h3F : 6'h01, 16'($urandom));
            run_one($sformatf("rnd%0d", n), ins, pc, rs, rt, $urandom_range(0, 3),
                    ref_model(ins, pc, rs, rt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1, cycles from driving ALU inputs to sampling AluOut/AluZero (legal 1..4).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports InstrValid in 1 / InstrReady out 1: instruction handshake.
REQ-006 SHALL have ports Instr in 32, PC in 32, RsData in 32, RtData in 32: instruction and operands, captured on handshake.
REQ-007 SHALL have ports AluControl out 4, AluIn1 out 32, AluIn2 out 32: drive the ALU.
REQ-008 SHALL have ports AluOut in 32, AluZero in 1: ALU result.
REQ-009 SHALL have ports ResultValid out 1 / ResultReady in 1: result handshake.
REQ-010 SHALL have ports Result out 32, BranchTaken out 1, BranchTarget out 32, Illegal out 1.

Function
REQ-011 SHALL implement states IDLE, DECODE, EXEC, BRTGT, DONE.
REQ-012 IDLE: InstrReady=1; InstrValid&InstrReady captures Instr/PC/RsData/RtData and moves to DECODE; no other state asserts InstrReady.
REQ-013 DECODE (1 cycle) SHALL map opcode/funct to AluControl: funct 0x24->0 AND, 0x25->1 OR, 0x20->2 ADD, 0x22->6 SUB, 0x2A->7 SLT, 0x27->12 NOR; opcode 0x08/0x23/0x2B->2 with sign-extended imm16 as AluIn2; opcode 0x04->6 with AluIn2=RtData.
REQ-014 Any other opcode/funct SHALL go DECODE->DONE with Illegal=1, Result=0, no ALU op issued.
REQ-015 EXEC SHALL hold AluControl/AluIn1/AluIn2 stable ALU_LATENCY cycles, then register AluOut into Result and AluZero internally.
REQ-016 Non-branch EXEC->DONE; beq EXEC->BRTGT with BranchTaken=AluZero.
REQ-017 BRTGT SHALL issue ADD with AluIn1=PC+4, AluIn2=simm16<<2 (32-bit wrap), register AluOut into BranchTarget after ALU_LATENCY cycles, then DONE; Result keeps the SUB output.
REQ-018 DONE: ResultValid=1, outputs stable until ResultReady; handshake returns to IDLE; ResultReady outside DONE is ignored.
REQ-019 Best-case latency accept->ResultValid SHALL be 2+ALU_LATENCY cycles (non-branch), 2+2*ALU_LATENCY (branch).
REQ-020 BranchTaken/BranchTarget SHALL read 0 for non-branch instructions.

Reset
REQ-021 reset SHALL force IDLE and zero AluControl, AluIn1, AluIn2, Result, BranchTaken, BranchTarget, Illegal, ResultValid; InstrReady=0 while reset is high.
REQ-022 reset mid-operation SHALL abandon the instruction with no ResultValid pulse; reset overrides simultaneous handshakes.

Configuration
REQ-023 Macro ALU_SEQ_BNE_EN defined: opcode 0x05 (bne) decodes as beq with BranchTaken=~AluZero.
REQ-024 Without ALU_SEQ_BNE_EN: opcode 0x05 is Illegal per REQ-014.

Structure
REQ-025 Shared package SHALL hold state enum, ALU control constants (AND/OR/ADD/SUB/SLT/NOR), opcode and funct constants.
REQ-026 Decode SHALL be a combinational sub-module alu_op_decode (Instr -> AluControl, operand selects, is_branch, illegal); FSM and registers stay in alu_op_sequencer.

Verification
REQ-027 add: RsData=5, RtData=7, funct 0x20 -> AluControl=2 seen, Result=12, Illegal=0, ResultValid 3 cycles after accept (ALU_LATENCY=1).
REQ-028 beq: RsData=RtData=9, PC=0x100, imm=0x0003 -> BranchTaken=1, BranchTarget=0x110; imm=0xFFFF -> BranchTarget=0x100.
REQ-029 Illegal: opcode 0x3F -> Illegal=1, Result=0, AluControl never leaves reset value.
REQ-030 Backpressure: ResultReady low 5 cycles -> ResultValid and Result held, InstrReady=0 throughout; accepted next after release.
REQ-031 Reset asserted in EXEC -> next cycle IDLE, all outputs 0, no ResultValid.
REQ-032 bne RsData=1, RtData=2: with ALU_SEQ_BNE_EN BranchTaken=1; without -> Illegal=1.
